vga_tile_renderer: RTL and testbench
====================================

// Module: vga_tile_renderer
// PURPOSE
// Pixel stage downstream of the VGA sync/counter generator. It takes the generator's pixel
// coordinates, active flag and pin-level syncs, and looks up a COLS x ROWS tile map of 4-bit
// cells (16x16 px each). It drives R/G/B with a fixed 2-cycle latency and delays the syncs to
// match. The host loads the map through a valid/ready write port; map RAM is cleared after reset.
// PARAMETERS
// COLS          48   tile columns (768 px / 16)
// ROWS          32   tile rows (512 lines / 16)
// CELL_LOG2     4    log2 of cell edge in pixels
// ADDR_W        11   map address width; 2**ADDR_W >= COLS*ROWS
// BLINK_FRAMES  30   frames per blink half-period, >= 1
// PORTS
// clk         in   1       pixel clock; everything on posedge
// rst         in   1       synchronous, active-high reset
// in_x        in   10      pixel column from timing generator
// in_y        in   9       pixel line from timing generator
// in_active   in   1       1 = visible pixel
// in_h_sync   in   1       pin-level h-sync (active-low)
// in_v_sync   in   1       pin-level v-sync (active-low)
// wr_valid    in   1       host write request
// wr_ready    out  1       1 = write accepted this cycle if wr_valid
// wr_addr     in   ADDR_W  cell index = row*COLS + col
// wr_data     in   4       [3]=blink, [2:0]={R,G,B}
// vga_h_sync  out  1       in_h_sync delayed 2 cycles
// vga_v_sync  out  1       in_v_sync delayed 2 cycles
// R, G, B     out  1 each  pixel colour, aligned with syncs
// BEHAVIOUR
// - Reset (rst=1 at an edge): R=G=B=0, vga_h_sync=vga_v_sync=1, wr_ready=0, blink phase=0,
//   frame count=0, FSM -> CLEAR at addr 0. Asserting rst mid-operation aborts everything and
//   restarts the clear.
// - FSM CLEAR: writes 4'h0 to one cell per cycle, addr 0..COLS*ROWS-1. wr_ready=0 throughout.
//   After the last cell -> RUN. wr_ready first reads 1 exactly COLS*ROWS cycles after rst falls.
// - FSM RUN: wr_ready=1. A write happens when wr_valid && wr_ready.
//   wr_addr >= COLS*ROWS is accepted and discarded.
// - Pipeline (latency 2, independent of FSM state):
//   - Cycle t: col = in_x>>CELL_LOG2, row = in_y>>CELL_LOG2; synchronous RAM read issued at
//     row*COLS+col.
//   - t+1: cell data available; in_active, the syncs and the out-of-range flag (col>=COLS or
//     row>=ROWS) are carried alongside.
//   - t+2: outputs registered.
// - Colour at t+2 is 0 if any of these hold: the delayed active flag is 0; the cell is out of
//   range; the FSM is in CLEAR; or cell[3]=1 and blink phase=1. Otherwise {R,G,B}=cell[2:0].
// - Syncs always pass through with the 2-cycle delay, including during CLEAR, so the monitor
//   keeps lock.
// - Read/write collision on the same address in the same cycle: read-first; the pixel shows the
//   old value and the new value is visible from the next read.
// - Blink: the frame counter increments on each falling edge of in_v_sync (1->0, sampled at clk).
//   On reaching BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles. The phase change takes
//   effect for pixels sampled at t >= the edge cycle + 1.
// - Widths: row*COLS is computed at ADDR_W bits; no truncation for legal parameters.
//   in_x/in_y wrap is the generator's concern.
// TESTING
// 1 Reset: rst=1 for 3 cycles, then 0 -> wr_ready=0 for 1536 cycles, 1 on cycle 1536;
//   R/G/B=0 throughout; syncs follow inputs delayed 2.
// 2 Write/read: write addr 49 data 4'h5. Drive x=16,y=16,active=1 at t -> {R,G,B}=3'b101 at
//   t+2 and not at t+1.
// 3 Blanking/range: cell 0=4'h7. x=0,y=0,active=0 -> RGB 0. Write cell 47=4'h7; x=767,y=0 ->
//   RGB 3'b111. x=768 (col 48), active=1 -> RGB 0.
// 4 Blink (BLINK_FRAMES=2 override): cell 0=4'hC. Phase 0 -> 3'b100. After 2 v_sync falling
//   edges -> 0. After 2 more -> 3'b100.
// 5 Collision: cell 10=4'h1. Same cycle: read addr 10 (x=160,y=0) and write 4'h2 -> output
//   3'b001. Next read of cell 10 -> 3'b010.
// 6 Mid-run reset: write 20 cells, pulse rst 1 cycle mid-frame -> wr_ready drops next cycle;
//   after clear all cells read 0; blink phase 0.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// Tile-map pixel stage: looks up a COLS x ROWS map of 4-bit cells
// (16x16 px each) from the timing generator's coordinates and drives
// R/G/B with a fixed 2-cycle latency, with the syncs delayed to match.
// The map RAM is cleared after reset, then the host loads it through a
// valid/ready write port.
//
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   in_x, in_y, in_active    pixel coordinates and visible flag
//   in_h_sync, in_v_sync     pin-level syncs (active-low)
//   wr_valid, wr_ready       host write handshake
//   wr_addr, wr_data         cell index (row*COLS+col), {blink, R, G, B}
//   vga_h_sync, vga_v_sync   syncs delayed 2 cycles
//   R, G, B                  pixel colour, aligned with the syncs
module vga_tile_renderer #(
    parameter int COLS         = 48,
    parameter int ROWS         = 32,
    parameter int CELL_LOG2    = 4,
    parameter int ADDR_W       = 11,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic              in_active,
    input  logic              in_h_sync,
    input  logic              in_v_sync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    output logic              vga_h_sync,
    output logic              vga_v_sync,
    output logic              R,
    output logic              G,
    output logic              B
);

    localparam int N_CELLS = COLS * ROWS;
    localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [ADDR_W:0]   N_CELLS_W  = (ADDR_W + 1)'(N_CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(N_CELLS - 1);
    localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]        COLS_X     = 10'(COLS);
    localparam logic [8:0]        ROWS_Y     = 9'(ROWS);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    // ---------------- control FSM ----------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              wr_ready_q, wr_ready_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ready_d = wr_ready_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                wr_ready_d = 1'b0;
                if (clr_addr_q == LAST_CELL) begin
                    state_d    = S_RUN;
                    clr_addr_d = '0;
                    // Registered so it reads 1 right after the last clear write.
                    wr_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                wr_ready_d = 1'b1;
            end
            default: begin
                state_d    = S_CLEAR;
                clr_addr_d = '0;
                wr_ready_d = 1'b0;
            end
        endcase
    end

    assign wr_ready = wr_ready_q;

    // ---------------- blink timing ----------------
    logic            vs_prev_q, vs_prev_d;
    logic [FC_W-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;
    logic            vs_fall;

    always_comb begin
        vs_fall   = vs_prev_q & ~in_v_sync;
        vs_prev_d = in_v_sync;
        frame_d   = frame_q;
        phase_d   = phase_q;
        if (vs_fall) begin
            if (frame_q == LAST_FRAME) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FC_W'(1);
            end
        end
    end

    // ---------------- address generation ----------------
    logic [9:0]        col;
    logic [8:0]        row;
    logic              oor;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_idx;

    always_comb begin
        col     = in_x >> CELL_LOG2;
        row     = in_y >> CELL_LOG2;
        oor     = (col >= COLS_X) || (row >= ROWS_Y);
        rd_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
        // Out-of-range cells are masked later; keep the RAM index legal.
        rd_idx  = oor ? '0 : rd_addr;
    end

    // ---------------- map RAM ----------------
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [3:0]        mem_wdata;
    logic [3:0]        mem_q [N_CELLS];
    logic [3:0]        rd_data_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = 4'h0;
        end else if (wr_valid && wr_ready_q) begin
            // Accepted but dropped when beyond the map.
            mem_we = ({1'b0, wr_addr} < N_CELLS_W);
        end
    end

    // Non-blocking read and write on the same edge give read-first.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem_q[rd_idx];
    end

    // ---------------- pixel pipeline ----------------
    logic       act1_q, act1_d;
    logic       oor1_q, oor1_d;
    logic       clr1_q, clr1_d;
    logic       ph1_q, ph1_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hs2_q, hs2_d;
    logic       vs2_q, vs2_d;
    logic       kill;

    always_comb begin
        act1_d = in_active;
        oor1_d = oor;
        clr1_d = (state_q == S_CLEAR);
        // Phase as seen in the sample cycle, so a toggle only hits later pixels.
        ph1_d  = phase_q;
        hs1_d  = in_h_sync;
        vs1_d  = in_v_sync;
        kill   = ~act1_q | oor1_q | clr1_q | (rd_data_q[3] & ph1_q);
        rgb_d  = kill ? 3'b000 : rd_data_q[2:0];
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            wr_ready_q <= 1'b0;
            vs_prev_q  <= 1'b1;
            frame_q    <= '0;
            phase_q    <= 1'b0;
            act1_q     <= 1'b0;
            oor1_q     <= 1'b0;
            clr1_q     <= 1'b1;
            ph1_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            rgb_q      <= 3'b000;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ready_q <= wr_ready_d;
            vs_prev_q  <= vs_prev_d;
            frame_q    <= frame_d;
            phase_q    <= phase_d;
            act1_q     <= act1_d;
            oor1_q     <= oor1_d;
            clr1_q     <= clr1_d;
            ph1_q      <= ph1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
        end
    end

    assign vga_h_sync = hs2_q;
    assign vga_v_sync = vs2_q;
    assign R          = rgb_q[2];
    assign G          = rgb_q[1];
    assign B          = rgb_q[0];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer: clear timing, lookup, blanking,
// range, blink, read/write collision and mid-run reset.
module tb_vga_tile_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic        in_active;
    logic        in_h_sync;
    logic        in_v_sync;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [3:0]  wr_data;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic        R, G, B;

    int n_vec = 0;
    int n_bad = 0;

    vga_tile_renderer #(
        .COLS(48), .ROWS(32), .CELL_LOG2(4),
        .ADDR_W(11), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_x(in_x), .in_y(in_y), .in_active(in_active),
        .in_h_sync(in_h_sync), .in_v_sync(in_v_sync),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .R(R), .G(G), .B(B)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       act;
        logic [2:0] rgb;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [10:0] a, input logic [3:0] d);
        chk("wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pix(input logic [9:0] x, input logic [8:0] y,
                       input logic a, output logic [2:0] rgb);
        in_x      = x;
        in_y      = y;
        in_active = a;
        step();
        step();
        rgb = {R, G, B};
    endtask

    task automatic vfall();
        in_v_sync = 1'b0;
        step();
        in_v_sync = 1'b1;
        step();
    endtask

    initial begin
        logic [2:0] rgb;
        logic       h_new;
        logic       h_d1;
        logic       v_new;
        logic       v_d1;
        int         cnt;
        int         a;

        tbl[0] = '{10'd16,  9'd16,  1'b1, 3'b101};
        tbl[1] = '{10'd31,  9'd31,  1'b1, 3'b101};
        tbl[2] = '{10'd0,   9'd0,   1'b0, 3'b000};
        tbl[3] = '{10'd0,   9'd0,   1'b1, 3'b111};
        tbl[4] = '{10'd767, 9'd0,   1'b1, 3'b111};
        tbl[5] = '{10'd768, 9'd0,   1'b1, 3'b000};
        tbl[6] = '{10'd1023,9'd0,   1'b1, 3'b000};
        tbl[7] = '{10'd32,  9'd16,  1'b1, 3'b000};
        tbl[8] = '{10'd767, 9'd511, 1'b1, 3'b011};
        tbl[9] = '{10'd0,   9'd511, 1'b1, 3'b000};

        rst       = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_active = 1'b0;
        in_h_sync = 1'b1;
        in_v_sync = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // 1: reset state, clear length, syncs during clear
        repeat (3) step();
        chk("rst_rgb", 32'({R, G, B}), 32'd0);
        chk("rst_hs", 32'(vga_h_sync), 32'd1);
        chk("rst_vs", 32'(vga_v_sync), 32'd1);
        chk("rst_rdy", 32'(wr_ready), 32'd0);
        rst  = 1'b0;
        h_d1 = 1'b1;
        v_d1 = 1'b1;
        for (int i = 1; i <= 1536; i++) begin
            h_new     = 1'($urandom_range(0, 1));
            // 8 falling edges: blink state ends back at phase 0.
            v_new     = (i < 64) ? (((i / 4) % 2) == 0) : 1'b1;
            in_h_sync = h_new;
            in_v_sync = v_new;
            in_x      = 10'($urandom_range(0, 767));
            in_y      = 9'($urandom_range(0, 511));
            in_active = 1'b1;
            step();
            chk("clr_rdy", 32'(wr_ready), (i == 1536) ? 32'd1 : 32'd0);
            chk("clr_rgb", 32'({R, G, B}), 32'd0);
            chk("clr_hs", 32'(vga_h_sync), 32'(h_d1));
            chk("clr_vs", 32'(vga_v_sync), 32'(v_d1));
            h_d1 = h_new;
            v_d1 = v_new;
        end
        in_h_sync = 1'b1;
        in_v_sync = 1'b1;
        step();

        // 2/3: table of lookups
        wr(11'd49, 4'h5);
        wr(11'd0, 4'h7);
        wr(11'd47, 4'h7);
        wr(11'd1535, 4'h3);
        wr(11'd2000, 4'h7);
        for (int i = 0; i < 10; i++) begin
            pix(tbl[i].x, tbl[i].y, tbl[i].act, rgb);
            chk($sformatf("tbl%0d", i), 32'(rgb), 32'(tbl[i].rgb));
        end

        // 2: latency exactly 2
        pix(10'd0, 9'd0, 1'b0, rgb);
        in_x      = 10'd16;
        in_y      = 9'd16;
        in_active = 1'b1;
        step();
        chk("lat_t1", 32'({R, G, B}), 32'd0);
        step();
        chk("lat_t2", 32'({R, G, B}), 32'b101);

        // 4: blink, including the toggle-cycle boundary
        wr(11'd0, 4'hC);
        pix(10'd0, 9'd0, 1'b1, rgb);
        chk("blink_p0", 32'(rgb), 32'b100);
        vfall();
        in_v_sync = 1'b0;
        step();
        in_v_sync = 1'b1;
        step();
        chk("blink_edge", 32'({R, G, B}), 32'b100);
        step();
        chk("blink_after", 32'({R, G, B}), 32'd0);
        pix(10'd0, 9'd0, 1'b1, rgb);
        chk("blink_p1", 32'(rgb), 32'd0);
        vfall();
        vfall();
        pix(10'd0, 9'd0, 1'b1, rgb);
        chk("blink_p0b", 32'(rgb), 32'b100);

        // 5: read/write collision is read-first
        wr(11'd10, 4'h1);
        in_x      = 10'd160;
        in_y      = 9'd0;
        in_active = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 11'd10;
        wr_data   = 4'h2;
        step();
        wr_valid = 1'b0;
        step();
        chk("coll_old", 32'({R, G, B}), 32'b001);
        pix(10'd160, 9'd0, 1'b1, rgb);
        chk("coll_new", 32'(rgb), 32'b010);

        // 6: mid-run reset with phase 1 and a loaded map
        vfall();
        vfall();
        pix(10'd0, 9'd0, 1'b1, rgb);
        chk("pre_rst_p1", 32'(rgb), 32'd0);
        for (int i = 100; i < 120; i++) wr(11'(i), 4'h7);
        pix(10'd64, 9'd32, 1'b1, rgb);
        chk("pre_rst_c100", 32'(rgb), 32'b111);
        rst = 1'b1;
        step();
        chk("mid_rst_rdy", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        cnt = 0;
        while (!wr_ready && cnt < 2000) begin
            step();
            cnt++;
        end
        chk("mid_clr_len", 32'(cnt), 32'd1536);
        for (int i = 100; i < 120; i++) begin
            a = i;
            pix(10'((a % 48) * 16), 9'((a / 48) * 16), 1'b1, rgb);
            chk($sformatf("cleared%0d", i), 32'(rgb), 32'd0);
        end
        wr(11'd0, 4'hC);
        pix(10'd0, 9'd0, 1'b1, rgb);
        chk("post_rst_p0", 32'(rgb), 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
